// File: rtl/sccb_init_seq.sv
// Table-driven SCCB bring-up sequencer: walks a register table and drives the bridge
// master port with writes, timed delays and read-verify transactions.
module sccb_init_seq #(
    parameter int unsigned TBL_AW     = 8,
    parameter logic [6:0]  DEV_ID     = 7'h21,
    parameter logic [15:0] DELAY_TICK = 16'd1000,
    parameter logic [19:0] TIMEOUT    = 20'd200000
) (
    input  logic              sccb_clk,
    input  logic              sccb_reset,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [19:0]       tbl_data,
    output logic [2:0]        mcmd,
    output logic [14:0]       maddr,
    output logic [7:0]        mdata,
    input  logic              scmdaccept,
    input  logic [1:0]        sresp,
    input  logic [7:0]        sdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [TBL_AW-1:0] err_index
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_DELAY  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_e;

    localparam logic [1:0] OP_WR      = 2'b00;
    localparam logic [1:0] OP_DLY     = 2'b01;
    localparam logic [1:0] OP_RD      = 2'b10;
    localparam logic [1:0] OP_END     = 2'b11;
    localparam logic [2:0] CMD_NONE   = 3'b000;
    localparam logic [2:0] CMD_WR     = 3'b001;
    localparam logic [2:0] CMD_RD     = 3'b010;
    localparam logic [1:0] RESP_DVA   = 2'b01;
    localparam logic [1:0] EC_TMO     = 2'b01;
    localparam logic [1:0] EC_VERIFY  = 2'b10;
    localparam logic [1:0] EC_OVERRUN = 2'b11;
    localparam logic [TBL_AW-1:0] IDX_ZERO = {TBL_AW{1'b0}};
    localparam logic [TBL_AW-1:0] IDX_ONE  = {{(TBL_AW-1){1'b0}}, 1'b1};
    localparam logic [TBL_AW-1:0] IDX_LAST = {TBL_AW{1'b1}};

    state_e            state_q, state_d;
    logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d, err_index_q, err_index_d;
    logic [2:0]        mcmd_q, mcmd_d, cmd_q, cmd_d;
    logic [14:0]       maddr_q, maddr_d;
    logic [7:0]        mdata_q, mdata_d, exp_q, exp_d, cap_q, cap_d;
    logic              got_q, got_d, is_rd_q, is_rd_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [19:0]       tmo_q, tmo_d;
    logic [31:0]       dly_q, dly_d;

    logic [1:0]  op_s;
    logic [31:0] dly_prod_s;
    logic [7:0]  rd_byte_s;
    logic        idle_like_s, tmo_hit_s, dva_s, rd_ok_s;
    state_e      adv_state_s;

    assign op_s        = tbl_data[19:18];
    assign dly_prod_s  = {16'h0000, tbl_data[15:0]} * {16'h0000, DELAY_TICK};
    assign idle_like_s = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign adv_state_s = (tbl_addr_q == IDX_LAST) ? S_ERROR : S_FETCH;
    assign tmo_hit_s   = (tmo_q == (TIMEOUT - 20'd1));
    assign dva_s       = (sresp == RESP_DVA);
    // A DVA landing in the same cycle the bridge frees up still counts as the read data.
    assign rd_byte_s   = got_q ? cap_q : sdata;
    assign rd_ok_s     = (got_q || dva_s) && (rd_byte_s == exp_q);

    // State and datapath registers.
    always_ff @(posedge sccb_clk) begin
        if (sccb_reset) begin
            state_q     <= S_IDLE;
            tbl_addr_q  <= IDX_ZERO;
            err_index_q <= IDX_ZERO;
            mcmd_q      <= CMD_NONE;
            cmd_q       <= CMD_NONE;
            maddr_q     <= 15'h0000;
            mdata_q     <= 8'h00;
            exp_q       <= 8'h00;
            cap_q       <= 8'h00;
            got_q       <= 1'b0;
            is_rd_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            tmo_q       <= 20'd0;
            dly_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            tbl_addr_q  <= tbl_addr_d;
            err_index_q <= err_index_d;
            mcmd_q      <= mcmd_d;
            cmd_q       <= cmd_d;
            maddr_q     <= maddr_d;
            mdata_q     <= mdata_d;
            exp_q       <= exp_d;
            cap_q       <= cap_d;
            got_q       <= got_d;
            is_rd_q     <= is_rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            tmo_q       <= tmo_d;
            dly_q       <= dly_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_d = S_FETCH;
                else       state_d = state_q;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    OP_END:  state_d = S_DONE;
                    OP_DLY:  state_d = (tbl_data[15:0] == 16'd0) ? adv_state_s : S_DELAY;
                    default: state_d = S_ISSUE;
                endcase
            end
            S_ISSUE: begin
                if (tmo_hit_s)                                   state_d = S_ERROR;
                else if ((mcmd_q != CMD_NONE) && !scmdaccept)    state_d = S_WAIT;
                else                                             state_d = S_ISSUE;
            end
            S_WAIT: begin
                if (tmo_hit_s)                   state_d = S_ERROR;
                else if (!scmdaccept)            state_d = S_WAIT;
                else if (is_rd_q && !rd_ok_s)    state_d = S_ERROR;
                else                             state_d = adv_state_s;
            end
            S_DELAY: begin
                if (dly_q == 32'd1) state_d = adv_state_s;
                else                state_d = S_DELAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output updates, keyed on the current state and the chosen transition.
    always_comb begin
        tbl_addr_d  = tbl_addr_q;
        err_index_d = err_index_q;
        mcmd_d      = mcmd_q;
        cmd_d       = cmd_q;
        maddr_d     = maddr_q;
        mdata_d     = mdata_q;
        exp_d       = exp_q;
        cap_d       = cap_q;
        got_d       = got_q;
        is_rd_d     = is_rd_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        tmo_d       = tmo_q;
        dly_d       = dly_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    tbl_addr_d = IDX_ZERO;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                end else begin
                    busy_d = busy_q;
                end
            end
            S_DECODE: begin
                tmo_d = 20'd0;
                got_d = 1'b0;
                if ((op_s == OP_WR) || (op_s == OP_RD)) begin
                    is_rd_d = (op_s == OP_RD);
                    cmd_d   = (op_s == OP_RD) ? CMD_RD : CMD_WR;
                    maddr_d = {DEV_ID, tbl_data[15:8]};
                    mdata_d = (op_s == OP_WR) ? tbl_data[7:0] : 8'h00;
                    exp_d   = tbl_data[7:0];
                    // Only raise the command while the bridge reports itself idle.
                    if (scmdaccept) mcmd_d = (op_s == OP_RD) ? CMD_RD : CMD_WR;
                    else            mcmd_d = CMD_NONE;
                end else begin
                    dly_d = dly_prod_s;
                end
            end
            S_ISSUE: begin
                tmo_d = tmo_q + 20'd1;
                if (mcmd_q == CMD_NONE) mcmd_d = scmdaccept ? cmd_q : CMD_NONE;
                else if (!scmdaccept)   mcmd_d = CMD_NONE;
                else                    mcmd_d = mcmd_q;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 20'd1;
                if (is_rd_q && dva_s && !got_q) begin
                    cap_d = sdata;
                    got_d = 1'b1;
                end else begin
                    got_d = got_q;
                end
            end
            S_DELAY: dly_d = dly_q - 32'd1;
            default: dly_d = dly_q;
        endcase

        if (!idle_like_s && (state_d == S_FETCH)) tbl_addr_d = tbl_addr_q + IDX_ONE;
        else                                      tbl_addr_d = tbl_addr_d;

        if ((state_q != S_ERROR) && (state_d == S_ERROR)) begin
            err_d       = 1'b1;
            busy_d      = 1'b0;
            mcmd_d      = CMD_NONE;
            err_index_d = tbl_addr_q;
            if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && tmo_hit_s) err_code_d = EC_TMO;
            else if ((state_q == S_WAIT) && is_rd_q && !rd_ok_s)            err_code_d = EC_VERIFY;
            else                                                            err_code_d = EC_OVERRUN;
        end else begin
            err_d = err_d;
        end

        if ((state_q == S_DECODE) && (state_d == S_DONE)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end else begin
            done_d = done_d;
        end
    end

    assign tbl_addr  = tbl_addr_q;
    assign mcmd      = mcmd_q;
    assign maddr     = maddr_q;
    assign mdata     = mdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_index = err_index_q;

endmodule
